// File: rtl/mmcm_drp_sequencer.sv
// rtl/mmcm_drp_sequencer.sv - DRP read-modify-write sequencer for one MMCME2_ADV reconfiguration
// Ports:
//   clk_usb, reset_i              : sole clock (also MMCM DCLK), synchronous active-high reset
//   cfg_we/idx/addr/mask/data     : table entry write port (ignored unless idle)
//   cfg_count, start              : number of entries to apply, start pulse
//   busy, done, error             : sequence status (error is sticky until next start)
//   drp_addr/den/dwe/din/dout/drdy: MMCM DRP port
//   mmcm_rst, mmcm_locked         : MMCM reset and lock status
module mmcm_drp_sequencer #(
    parameter int pENTRY_AW     = 3,
    parameter int pDRDY_TIMEOUT = 255,
    parameter int pLOCK_TIMEOUT = 65535
) (
    input  logic                 clk_usb,
    input  logic                 reset_i,
    input  logic                 cfg_we,
    input  logic [pENTRY_AW-1:0] cfg_idx,
    input  logic [6:0]           cfg_addr,
    input  logic [15:0]          cfg_mask,
    input  logic [15:0]          cfg_data,
    input  logic [pENTRY_AW:0]   cfg_count,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [6:0]           drp_addr,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [15:0]          drp_din,
    input  logic [15:0]          drp_dout,
    input  logic                 drp_drdy,
    output logic                 mmcm_rst,
    input  logic                 mmcm_locked
);

    localparam int DEPTH = 1 << pENTRY_AW;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ON,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RST_OFF,
        S_LOCK_WAIT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    // Entry layout: {addr[38:32], mask[31:16], data[15:0]}
    logic [38:0]          table_q [DEPTH];
    logic [pENTRY_AW-1:0] ptr_q;
    logic [pENTRY_AW:0]   count_q;
    logic [15:0]          rd_q;
    logic [15:0]          wcnt_q;
    logic                 error_q;

    logic [38:0] entry;
    logic        last_entry;
    logic        drdy_timeout;
    logic        lock_timeout;
    logic        in_drp_wait;

    assign entry        = table_q[ptr_q];
    assign last_entry   = ({1'b0, ptr_q} + 1'b1) == count_q;
    assign in_drp_wait  = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    // The counter holds the number of wait cycles already elapsed, so the
    // last permitted cycle is the one where it equals TIMEOUT-1.
    assign drdy_timeout = wcnt_q == 16'(pDRDY_TIMEOUT - 1);
    assign lock_timeout = wcnt_q == 16'(pLOCK_TIMEOUT - 1);

    // Table storage is deliberately not reset.
    always_ff @(posedge clk_usb) begin
        if (cfg_we && state_q == S_IDLE) begin
            table_q[cfg_idx] <= {cfg_addr, cfg_mask, cfg_data};
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? S_FIN : S_RST_ON;
                end
            end
            S_RST_ON: state_d = S_RD_REQ;
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drp_drdy)          state_d = S_WR_REQ;
                else if (drdy_timeout) state_d = S_FIN;
            end
            S_WR_REQ: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drp_drdy)          state_d = last_entry ? S_RST_OFF : S_RD_REQ;
                else if (drdy_timeout) state_d = S_FIN;
            end
            S_RST_OFF: state_d = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                if (mmcm_locked || lock_timeout) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            ptr_q   <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wcnt_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                ptr_q   <= '0;
                count_q <= cfg_count;
                error_q <= 1'b0;
            end
            if (state_q == S_RD_WAIT && drp_drdy) begin
                rd_q <= drp_dout;
            end
            if (state_q == S_WR_WAIT && drp_drdy && !last_entry) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if ((in_drp_wait && !drp_drdy && drdy_timeout) ||
                (state_q == S_LOCK_WAIT && !mmcm_locked && lock_timeout)) begin
                error_q <= 1'b1;
            end
            // Restart the wait counter on every request and on reset release.
            if (state_q == S_RD_REQ || state_q == S_WR_REQ || state_q == S_RST_OFF) begin
                wcnt_q <= '0;
            end else if (in_drp_wait || state_q == S_LOCK_WAIT) begin
                wcnt_q <= wcnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE) && (state_q != S_FIN);
        done     = state_q == S_FIN;
        error    = error_q;
        drp_den  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
        drp_dwe  = state_q == S_WR_REQ;
        drp_addr = drp_den ? entry[38:32] : 7'd0;
        drp_din  = drp_dwe ? ((rd_q & entry[31:16]) | (entry[15:0] & ~entry[31:16])) : 16'd0;
        mmcm_rst = (state_q == S_RST_ON)  || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                   (state_q == S_WR_REQ)  || (state_q == S_WR_WAIT);
    end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb/tb_mmcm_drp_sequencer.sv - scoreboard bench for mmcm_drp_sequencer
module tb_mmcm_drp_sequencer;

    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic [3:0]  cfg_count;
    logic        start;
    logic        busy, done, error;
    logic [6:0]  drp_addr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_din;
    logic [15:0] drp_dout;
    logic        drp_drdy;
    logic        mmcm_rst;
    logic        mmcm_locked;

    mmcm_drp_sequencer dut (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .busy(busy), .done(done), .error(error),
        .drp_addr(drp_addr), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_din(drp_din), .drp_dout(drp_dout), .drp_drdy(drp_drdy),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    always #5 clk_usb = ~clk_usb;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_done[$];
    int   checks   = 0;
    int   failures = 0;
    int   den_count = 0;
    logic rst_seen  = 1'b0;
    logic drdy_en   = 1'b1;
    logic locked_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic write_entry(input logic [2:0] idx, input logic [6:0] a,
                               input logic [15:0] m, input logic [15:0] d);
        @(posedge clk_usb); #1;
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_mask = m; cfg_data = d;
        @(posedge clk_usb); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_seq(input logic [3:0] cnt);
        @(posedge clk_usb); #1;
        cfg_count = cnt;
        start = 1'b1;
        @(posedge clk_usb); #1;
        start = 1'b0;
    endtask

    // Returns n = number of cycles after the start cycle at which done was seen.
    task automatic wait_done(input int budget, output int n);
        logic got;
        n   = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(negedge clk_usb);
            n++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within %0d cycles", budget);
        end
    endtask

    // DRP and lock model: DO fixed at 0xFFFF, DRDY 3 cycles after DEN,
    // LOCKED rises 3 cycles after RST is released.
    int pend = 0;
    int lcnt = 0;
    initial begin
        drp_drdy    = 1'b0;
        mmcm_locked = 1'b0;
        drp_dout    = 16'hFFFF;
        forever begin
            @(negedge clk_usb);
            drp_drdy = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) drp_drdy = 1'b1;
            end
            if (drp_den && drdy_en) pend = 3;
            if (mmcm_rst) begin
                mmcm_locked = 1'b0;
                lcnt = 0;
            end else if (!locked_en) begin
                mmcm_locked = 1'b0;
            end else if (!mmcm_locked) begin
                lcnt++;
                if (lcnt >= 3) mmcm_locked = 1'b1;
            end
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a write or done.
    initial begin
        forever begin
            @(negedge clk_usb);
            if (mmcm_rst) rst_seen = 1'b1;
            if (drp_den) begin
                den_count++;
                check("rst_during_den", {31'd0, mmcm_rst}, 32'd1);
            end
            if (drp_dwe && !drp_den) check("dwe_without_den", 32'd1, 32'd0);
            if (drp_den && drp_dwe) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {25'd0, drp_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", {25'd0, drp_addr}, {25'd0, w.addr});
                    check("wr_data", {16'd0, drp_din}, {16'd0, w.data});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic e;
                    e = exp_done.pop_front();
                    check("done_error", {31'd0, error}, {31'd0, e});
                end
                check("done_rst_low", {31'd0, mmcm_rst}, 32'd0);
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy},     32'd0);
        check({tag, "_done"},  {31'd0, done},     32'd0);
        check({tag, "_error"}, {31'd0, error},    32'd0);
        check({tag, "_den"},   {31'd0, drp_den},  32'd0);
        check({tag, "_dwe"},   {31'd0, drp_dwe},  32'd0);
        check({tag, "_rst"},   {31'd0, mmcm_rst}, 32'd0);
        check({tag, "_addr"},  {25'd0, drp_addr}, 32'd0);
        check({tag, "_din"},   {16'd0, drp_din},  32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int k;
        reset_i = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_mask = '0;
        cfg_data = '0; cfg_count = '0; start = 1'b0;
        repeat (3) @(posedge clk_usb);
        #1;
        reset_i = 1'b0;
        check_reset_outputs("reset");

        write_entry(3'd0, 7'h08, 16'h1000, 16'h0041);
        write_entry(3'd1, 7'h09, 16'hFC00, 16'h0080);

        // 1: two-entry sequence with good lock
        push_wr(7'h08, 16'h1041);
        push_wr(7'h09, 16'hFC80);
        exp_done.push_back(1'b0);
        start_seq(4'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(100, n);
        check("t1_latency", n, 32'd21);

        // 2: zero entries
        repeat (5) @(posedge clk_usb);
        d0 = den_count;
        rst_seen = 1'b0;
        exp_done.push_back(1'b0);
        start_seq(4'd0);
        wait_done(10, n);
        check("t2_latency", n, 32'd1);
        check("t2_no_den", den_count, d0);
        check("t2_no_rst", {31'd0, rst_seen}, 32'd0);

        // 3: DRDY never returns
        repeat (5) @(posedge clk_usb);
        drdy_en = 1'b0;
        exp_done.push_back(1'b1);
        start_seq(4'd1);
        wait_done(400, n);
        check("t3_latency", n, 32'd258);
        check("t3_error", {31'd0, error}, 32'd1);
        drdy_en = 1'b1;

        // 4: lock never arrives, then recovers
        repeat (5) @(posedge clk_usb);
        locked_en = 1'b0;
        push_wr(7'h08, 16'h1041);
        exp_done.push_back(1'b1);
        start_seq(4'd1);
        wait_done(70000, n);
        check("t4_latency", n, 32'd65546);
        locked_en = 1'b1;
        repeat (8) @(posedge clk_usb);
        push_wr(7'h08, 16'h1041);
        exp_done.push_back(1'b0);
        start_seq(4'd1);
        check("t4_error_cleared", {31'd0, error}, 32'd0);
        wait_done(100, n);

        // 5: start and cfg_we while busy are ignored
        repeat (5) @(posedge clk_usb);
        push_wr(7'h08, 16'h1041);
        push_wr(7'h09, 16'hFC80);
        exp_done.push_back(1'b0);
        start_seq(4'd2);
        repeat (3) @(posedge clk_usb);
        #1;
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0;
        cfg_addr = 7'h7F; cfg_mask = 16'h0000; cfg_data = 16'hDEAD;
        @(posedge clk_usb); #1;
        start = 1'b0; cfg_we = 1'b0;
        wait_done(100, n);
        repeat (10) @(posedge clk_usb);
        #1;
        check("t5_idle", {31'd0, busy}, 32'd0);
        push_wr(7'h08, 16'h1041);
        exp_done.push_back(1'b0);
        start_seq(4'd1);
        wait_done(100, n);

        // 6: reset in WR_WAIT
        repeat (5) @(posedge clk_usb);
        push_wr(7'h08, 16'h1041);
        start_seq(4'd2);
        k = 0;
        while (k < 50 && !drp_dwe) begin
            @(negedge clk_usb);
            k++;
        end
        check("t6_reached_write", {31'd0, drp_dwe}, 32'd1);
        @(posedge clk_usb); #1;
        reset_i = 1'b1;
        @(posedge clk_usb); #1;
        reset_i = 1'b0;
        check_reset_outputs("t6");
        repeat (8) @(posedge clk_usb);
        push_wr(7'h08, 16'h1041);
        push_wr(7'h09, 16'hFC80);
        exp_done.push_back(1'b0);
        start_seq(4'd2);
        wait_done(100, n);
        check("t6_latency", n, 32'd21);

        repeat (5) @(posedge clk_usb);
        check("left_writes", exp_wr.size(), 32'd0);
        check("left_dones", exp_done.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
